// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the write-back stage / mul-div unit (master) and the
// register-file write-port arbiter (slave).
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            p_we;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_data;
    logic            m_valid;
    logic            m_ready;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic            rd_we;
    logic [4:0]      rd_index;
    logic [XLEN-1:0] rd_data;
    logic            stall;
    logic            m_pending;

    modport master (
        output p_we, p_rd, p_data, m_valid, m_rd, m_data,
        input  m_ready, rd_we, rd_index, rd_data, stall, m_pending
    );

    modport slave (
        input  p_we, p_rd, p_data, m_valid, m_rd, m_data,
        output m_ready, rd_we, rd_index, rd_data, stall, m_pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline (priority) and a
// FIFO-buffered mul/div unit, with a starvation stall so M results always drain.
module regfile_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stall_q, stall_d;
    logic            rd_we_q, rd_we_d;
    logic [4:0]      rd_index_q, rd_index_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic   full, m_ready, push, pop, head_valid, p_act, grant_m, denied;
    entry_t head;

    always_comb begin
        full       = (count_q == (PW+1)'(FIFO_DEPTH));
        m_ready    = !full && i_rst_n;
        push       = bus.m_valid && m_ready;
        head       = mem_q[rd_ptr_q];
        head_valid = (count_q != '0);
        p_act      = bus.p_we && (bus.p_rd != 5'd0) && !stall_q;

        pop        = 1'b0;
        grant_m    = 1'b0;
        denied     = 1'b0;
        rd_we_d    = 1'b0;
        rd_index_d = rd_index_q;
        rd_data_d  = rd_data_q;
        stall_d    = 1'b0;
        cnt_d      = '0;

        // An x0 head is dropped silently and never blocks the pipeline.
        if (head_valid && head.rd == 5'd0) begin
            pop = 1'b1;
            if (p_act) begin
                rd_we_d    = 1'b1;
                rd_index_d = bus.p_rd;
                rd_data_d  = bus.p_data;
            end
        end else if (head_valid && (!p_act || stall_q)) begin
            pop        = 1'b1;
            grant_m    = 1'b1;
            rd_we_d    = 1'b1;
            rd_index_d = head.rd;
            rd_data_d  = head.data;
        end else if (p_act) begin
            denied     = head_valid;
            rd_we_d    = 1'b1;
            rd_index_d = bus.p_rd;
            rd_data_d  = bus.p_data;
        end

        if (denied) begin
            if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
                stall_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_index_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            stall_q    <= stall_d;
            rd_we_q    <= rd_we_d;
            rd_index_q <= rd_index_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: bus.m_rd, data: bus.m_data};
        end
    end

    assign bus.m_ready   = m_ready;
    assign bus.rd_we     = rd_we_q;
    assign bus.rd_index  = rd_index_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.stall     = stall_q;
    assign bus.m_pending = (count_q != '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus randomized traffic checked against a queue-based
// model of the write-port arbiter.
module tb_regfile_wb_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;

    regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    regfile_wb_arbiter #(
        .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit              rst;
        bit              pwe;
        bit [4:0]        prd;
        bit [XLEN-1:0]   pdata;
        bit              mv;
        bit [4:0]        mrd;
        bit [XLEN-1:0]   mdata;
        bit              ewe;
        bit [4:0]        eidx;
        bit [XLEN-1:0]   edata;
        bit              est;
        bit              epend;
        bit              erdy;
    } vec_t;

    typedef struct {
        bit [4:0]      rd;
        bit [XLEN-1:0] data;
    } ent_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    ent_t          mq[$];
    int            m_starve;
    bit            m_stall;
    bit            x_we;
    bit [4:0]      x_idx;
    bit [XLEN-1:0] x_data;
    bit            x_rdy;

    task automatic add(input bit rst, input bit pwe, input bit [4:0] prd,
                       input bit [XLEN-1:0] pdata, input bit mv, input bit [4:0] mrd,
                       input bit [XLEN-1:0] mdata, input bit ewe, input bit [4:0] eidx,
                       input bit [XLEN-1:0] edata, input bit est, input bit epend,
                       input bit erdy);
        vec_t v;
        v = '{rst, pwe, prd, pdata, mv, mrd, mdata, ewe, eidx, edata, est, epend, erdy};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int tag, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, tag, act, exp);
        end
    endtask

    // Applies one cycle's worth of inputs to the model, producing the
    // outputs expected right after the next rising edge.
    task automatic model_step(input bit rst, input bit pwe, input bit [4:0] prd,
                              input bit [XLEN-1:0] pdata, input bit mv,
                              input bit [4:0] mrd, input bit [XLEN-1:0] mdata);
        bit   accept, pact, nstall;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_starve = 0;
            m_stall  = 0;
            x_we = 0; x_idx = 0; x_data = 0;
            x_rdy = 0;
            return;
        end
        accept = mv && (mq.size() < DEPTH);
        pact   = pwe && prd != 0 && !m_stall;
        nstall = 0;
        x_we   = 0;
        if (mq.size() > 0 && mq[0].rd == 0) begin
            void'(mq.pop_front());
            if (pact) begin x_we = 1; x_idx = prd; x_data = pdata; end
        end else if (mq.size() > 0 && (!pact || m_stall)) begin
            e = mq.pop_front();
            x_we = 1; x_idx = e.rd; x_data = e.data;
            m_starve = 0;
        end else if (pact) begin
            x_we = 1; x_idx = prd; x_data = pdata;
            if (mq.size() > 0) begin
                m_starve++;
                if (m_starve == LIMIT) begin nstall = 1; m_starve = 0; end
            end else begin
                m_starve = 0;
            end
        end else begin
            m_starve = 0;
        end
        if (accept) begin
            e.rd = mrd; e.data = mdata;
            mq.push_back(e);
        end
        m_stall = nstall;
        x_rdy   = mq.size() < DEPTH;
    endtask

    task automatic drive(input bit rst, input bit pwe, input bit [4:0] prd,
                         input bit [XLEN-1:0] pdata, input bit mv, input bit [4:0] mrd,
                         input bit [XLEN-1:0] mdata);
        @(negedge clk);
        rst_n       = rst;
        bus.p_we    = pwe;
        bus.p_rd    = prd;
        bus.p_data  = pdata;
        bus.m_valid = mv;
        bus.m_rd    = mrd;
        bus.m_data  = mdata;
        model_step(rst, pwe, prd, pdata, mv, mrd, mdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        bus.p_we = 0; bus.p_rd = 0; bus.p_data = 0;
        bus.m_valid = 0; bus.m_rd = 0; bus.m_data = 0;

        // reset held with P requesting, then release
        add(0,1,5,'hAB,0,0,0,      0,0,0,0,0,0);
        add(0,1,5,'hAB,0,0,0,      0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,         0,0,0,0,0,1);
        // P only, then P to x0 (index/data hold)
        add(1,1,5,'hAB,0,0,0,      1,5,'hAB,0,0,1);
        add(1,1,0,'hCD,0,0,0,      0,5,'hAB,0,0,1);
        // M into an idle pipe
        add(1,0,0,0,1,7,'h1234,    0,5,'hAB,0,1,1);
        add(1,0,0,0,0,0,0,         1,7,'h1234,0,0,1);
        // starvation: four denied cycles, stall, M write, P resumes
        add(1,1,9,'h99,1,3,'h33,   1,9,'h99,0,1,1);
        add(1,1,9,'h99,0,0,0,      1,9,'h99,0,1,1);
        add(1,1,9,'h99,0,0,0,      1,9,'h99,0,1,1);
        add(1,1,9,'h99,0,0,0,      1,9,'h99,0,1,1);
        add(1,1,9,'h99,0,0,0,      1,9,'h99,1,1,1);
        add(1,1,9,'h99,0,0,0,      1,3,'h33,0,0,1);
        add(1,1,9,'h99,0,0,0,      1,9,'h99,0,0,1);
        // full FIFO under continuous P traffic
        add(1,1,9,'h99,1,10,'hA0,  1,9,'h99,0,1,1);
        add(1,1,9,'h99,1,11,'hB0,  1,9,'h99,0,1,0);
        add(1,1,9,'h99,1,12,'hC0,  1,9,'h99,0,1,0);
        add(1,1,9,'h99,1,12,'hC0,  1,9,'h99,0,1,0);
        add(1,1,9,'h99,1,12,'hC0,  1,9,'h99,1,1,0);
        add(1,1,9,'h99,1,12,'hC0,  1,10,'hA0,0,1,1);
        add(1,1,9,'h99,1,12,'hC0,  1,9,'h99,0,1,0);
        add(1,0,0,0,0,0,0,         1,11,'hB0,0,1,1);
        add(1,0,0,0,0,0,0,         1,12,'hC0,0,0,1);
        // x0 head dropped while P writes x4
        add(1,0,0,0,1,0,'hDEAD,    0,12,'hC0,0,1,1);
        add(1,1,4,'h44,0,0,0,      1,4,'h44,0,0,1);
        // reset with two entries queued
        add(1,1,9,'h99,1,13,'hD0,  1,9,'h99,0,1,1);
        add(1,1,9,'h99,1,14,'hE0,  1,9,'h99,0,1,0);
        add(0,1,9,'h99,0,0,0,      0,0,0,0,0,0);
        add(1,0,0,0,0,0,0,         0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,         0,0,0,0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].pwe, vecs[i].prd, vecs[i].pdata,
                  vecs[i].mv, vecs[i].mrd, vecs[i].mdata);
            check("vec_we",      i, XLEN'(bus.rd_we),     XLEN'(vecs[i].ewe));
            check("vec_index",   i, XLEN'(bus.rd_index),  XLEN'(vecs[i].eidx));
            check("vec_data",    i, bus.rd_data,          vecs[i].edata);
            check("vec_stall",   i, XLEN'(bus.stall),     XLEN'(vecs[i].est));
            check("vec_pending", i, XLEN'(bus.m_pending), XLEN'(vecs[i].epend));
            check("vec_ready",   i, XLEN'(bus.m_ready),   XLEN'(vecs[i].erdy));
        end

        for (int c = 0; c < 600; c++) begin
            bit            rst, pwe, mv;
            bit [4:0]      prd, mrd;
            bit [XLEN-1:0] pd, md;
            rst = ($urandom_range(0, 79) != 0);
            pwe = ($urandom_range(0, 3) != 0);
            prd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mv  = ($urandom_range(0, 1) != 0);
            mrd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pd  = {32'($urandom), 32'($urandom)};
            md  = {32'($urandom), 32'($urandom)};
            drive(rst, pwe, prd, pd, mv, mrd, md);
            check("rnd_we",      c, XLEN'(bus.rd_we),     XLEN'(x_we));
            check("rnd_stall",   c, XLEN'(bus.stall),     XLEN'(m_stall));
            check("rnd_pending", c, XLEN'(bus.m_pending), XLEN'(mq.size() != 0));
            check("rnd_ready",   c, XLEN'(bus.m_ready),   XLEN'(x_rdy && rst));
            if (rst) begin
                check("rnd_index", c, XLEN'(bus.rd_index), XLEN'(x_idx));
                check("rnd_data",  c, bus.rd_data,         x_data);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
